// File: rtl/reed_speed_meter.sv
// Wheel-sensor front end: reed synchroniser/debouncer, revolution period
// counter, restoring speed divider, moving/timeout FSM, max speed and trip
// distance accumulation.
module reed_speed_meter #(
  parameter int unsigned F_CLK     = 2048,
  parameter int unsigned CIRC_W    = 8,
  parameter int unsigned SPEED_W   = 7,
  parameter int unsigned SPEED_SAT = 99,
  parameter int unsigned MIN_SPEED = 3,
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned DIST_W    = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               reed,
  input  logic [CIRC_W-1:0]  circ,
  output logic [SPEED_W-1:0] speed,
  output logic               speed_valid,
  output logic               moving,
  output logic [SPEED_W-1:0] max_speed,
  output logic [DIST_W-1:0]  distance,
  output logic               busy
);

  // Numerator scale: circ[cm] * F_CLK * 36 / (period * 1000) gives km/h.
  localparam int unsigned K_NUM = F_CLK * 36;
  localparam int unsigned K_DEN = 1000;
  localparam int unsigned K_TMO = MIN_SPEED * 1000;
  localparam int unsigned NUM_W = CIRC_W + $clog2(K_NUM + 1);
  localparam longint unsigned NUM_MAX = ((64'd1 << CIRC_W) - 64'd1) * 64'(K_NUM);
  // Period counter reaches the timeout threshold at the largest circumference, plus headroom bit.
  localparam int unsigned PER_W = $clog2(NUM_MAX / 64'(K_TMO) + 64'd2) + 1;
  localparam int unsigned DEN_W = PER_W + 1 + $clog2(K_DEN + 1);
  localparam int unsigned LHS_W = PER_W + $clog2(K_TMO + 1);
  localparam int unsigned CMP_W = (LHS_W > NUM_W) ? LHS_W : NUM_W;
  localparam int unsigned CNT_W = $clog2(NUM_W + 1);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic              sync1_q, sync2_q, filt_q, filtPrev_q;
  logic [DB_W-1:0]   dbCnt_q;
  logic              rev;
  logic [PER_W-1:0]  per_q;
  logic [CMP_W-1:0]  tmoLhs, tmoRhs;
  logic              tmoOver, startDiv, timeout;

  logic              divBusy_q, divDone_q;
  logic [CNT_W-1:0]  divCnt_q;
  logic [NUM_W-1:0]  num_q;
  logic [DEN_W-1:0]  den_q, rem_q;
  logic [DEN_W:0]    remShift;
  logic [DEN_W-1:0]  remSub;
  logic              remFits;

  logic [SPEED_W-1:0] speed_q, maxSpeed_q, speedSat;
  logic               speedValid_q;
  logic [DIST_W-1:0]  distance_q, distNext;
  logic [DIST_W:0]    distSum;

  // Synchronise the raw contact and accept a high level only after DEBOUNCE stable clocks; trip clear leaves this path alone so a held contact cannot re-fire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      filtPrev_q <= 1'b0;
      dbCnt_q    <= '0;
    end else begin
      sync1_q    <= reed;
      sync2_q    <= sync1_q;
      filtPrev_q <= filt_q;
      if (!sync2_q) begin
        dbCnt_q <= '0;
        filt_q  <= 1'b0;
      end else if (!filt_q) begin
        if (dbCnt_q == DB_W'(DEBOUNCE - 1)) begin
          filt_q <= 1'b1;
        end else begin
          dbCnt_q <= dbCnt_q + 1'b1;
        end
      end
    end
  end

  assign rev = filt_q & ~filtPrev_q;

  assign tmoLhs  = CMP_W'(per_q) * CMP_W'(K_TMO);
  assign tmoRhs  = CMP_W'(circ) * CMP_W'(K_NUM);
  assign tmoOver = tmoLhs > tmoRhs;

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: first revolution arms RUN, a too-long gap drops back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rev) state_d = RUN;
      RUN:  if (!rev && tmoOver) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // FSM outputs: moving flag, division start and timeout events.
  always_comb begin
    moving   = (state_q == RUN);
    startDiv = (state_q == RUN) && rev;
    timeout  = (state_q == RUN) && !rev && tmoOver;
  end

  // Period counter restarts on every revolution or timeout and saturates otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      per_q <= '0;
    end else if (clear || rev || timeout) begin
      per_q <= '0;
    end else if (per_q != '1) begin
      per_q <= per_q + 1'b1;
    end
  end

  assign remShift = {rem_q, num_q[NUM_W-1]};
  assign remFits  = remShift >= {1'b0, den_q};
  assign remSub   = remShift[DEN_W-1:0] - den_q;

  // Restoring divider, one quotient bit per clock; a new revolution restarts it with fresh operands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      divBusy_q <= 1'b0;
      divDone_q <= 1'b0;
      divCnt_q  <= '0;
      num_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
    end else if (clear) begin
      divBusy_q <= 1'b0;
      divDone_q <= 1'b0;
      divCnt_q  <= '0;
      num_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
    end else if (timeout) begin
      divBusy_q <= 1'b0;
      divDone_q <= 1'b0;
    end else if (startDiv) begin
      divBusy_q <= 1'b1;
      divDone_q <= 1'b0;
      divCnt_q  <= CNT_W'(NUM_W);
      num_q     <= NUM_W'(circ) * NUM_W'(K_NUM);
      den_q     <= (DEN_W'(per_q) + DEN_W'(1)) * DEN_W'(K_DEN);
      rem_q     <= '0;
    end else if (divBusy_q) begin
      num_q    <= {num_q[NUM_W-2:0], remFits};
      rem_q    <= remFits ? remSub : remShift[DEN_W-1:0];
      divCnt_q <= divCnt_q - 1'b1;
      if (divCnt_q == CNT_W'(1)) begin
        divBusy_q <= 1'b0;
        divDone_q <= 1'b1;
      end
    end else begin
      divDone_q <= 1'b0;
    end
  end

  assign speedSat = (num_q > NUM_W'(SPEED_SAT)) ? SPEED_W'(SPEED_SAT) : num_q[SPEED_W-1:0];
  assign distSum  = {1'b0, distance_q} + (DIST_W + 1)'(circ);
  assign distNext = distSum[DIST_W] ? '1 : distSum[DIST_W-1:0];

  // Published speed, max speed and trip distance; clear wins over every other update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      speed_q      <= '0;
      speedValid_q <= 1'b0;
      maxSpeed_q   <= '0;
      distance_q   <= '0;
    end else if (clear) begin
      speed_q      <= '0;
      speedValid_q <= 1'b0;
      maxSpeed_q   <= '0;
      distance_q   <= '0;
    end else begin
      speedValid_q <= 1'b0;
      if (timeout) begin
        speed_q <= '0;
      end else if (divDone_q) begin
        speed_q      <= speedSat;
        speedValid_q <= 1'b1;
      end
      if (speedValid_q && (speed_q > maxSpeed_q)) begin
        maxSpeed_q <= speed_q;
      end
      if (rev) begin
        distance_q <= distNext;
      end
    end
  end

  assign speed       = speed_q;
  assign speed_valid = speedValid_q;
  assign max_speed   = maxSpeed_q;
  assign distance    = distance_q;
  assign busy        = divBusy_q;

endmodule

// File: tb/tb_reed_speed_meter.sv
// Self-checking bench for reed_speed_meter: table of revolution periods with
// fixed expectations, hand sequences for timing corners, and a randomized run
// against a behavioural speed/distance model.
module tb_reed_speed_meter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       reed  = 1'b0;
  logic [7:0] circ  = 8'd208;
  logic [6:0] speed, max_speed;
  logic       speed_valid, moving, busy;
  logic [23:0] distance;

  int testsRun    = 0;
  int testsFailed = 0;
  int svCount     = 0;

  logic busyLog [0:39];
  logic svLog   [0:39];

  int mMoving, mSpeed, mMax, mValid;
  longint mDist;

  typedef struct {
    int period;
    int expSpeed;
    int expMoving;
    int expMax;
    int expDist;
    int expSv;
  } vec_t;

  vec_t tbl [6];

  reed_speed_meter dut (
    .clock(clock), .reset(reset), .clear(clear), .reed(reed), .circ(circ),
    .speed(speed), .speed_valid(speed_valid), .moving(moving),
    .max_speed(max_speed), .distance(distance), .busy(busy)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Count speed_valid strobes.
  always @(negedge clock) begin
    if (speed_valid === 1'b1) svCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One 40-clock window starting at a negedge: reed high for 'width' clocks, clear pulsed at 'clearAt'.
  task automatic applyStimulus(input int width, input int clearAt);
    for (int k = 0; k < 40; k++) begin
      busyLog[k] = busy;
      svLog[k]   = speed_valid;
      reed  = (k < width);
      clear = (k == clearAt);
      @(negedge clock);
    end
    reed  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    reed  = 1'b0;
    clear = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic revPeriod(input int p);
    idle(p - 40);
    applyStimulus(8, -1);
  endtask

  // Behavioural model: one revolution arriving p clocks after the previous one.
  task automatic modelRev(input int p, input int c);
    longint num;
    longint q;
    num = longint'(c) * 2048 * 36;
    if (mMoving == 0) begin
      mMoving = 1;
    end else if (longint'(p - 2) * 3 * 1000 > num) begin
      mSpeed = 0;
    end else begin
      q = num / (longint'(p) * 1000);
      mSpeed = (q > 99) ? 99 : int'(q);
      mValid++;
      if (mSpeed > mMax) mMax = mSpeed;
    end
    mDist = mDist + c;
    if (mDist > 64'hFFFFFF) mDist = 64'hFFFFFF;
  endtask

  task automatic checkAll(input string tag, input int s, input int mv, input int mx, input int d);
    checkOutput({tag, " speed"}, 32'(speed), s);
    checkOutput({tag, " moving"}, 32'(moving), mv);
    checkOutput({tag, " max_speed"}, 32'(max_speed), mx);
    checkOutput({tag, " distance"}, 32'(distance), d);
  endtask

  initial begin
    int svBase;
    int p, c;

    tbl[0] = '{0,    0,  1, 0,  208,  0};
    tbl[1] = '{2048, 7,  1, 7,  416,  1};
    tbl[2] = '{256,  59, 1, 59, 624,  2};
    tbl[3] = '{200,  76, 1, 76, 832,  3};
    tbl[4] = '{2048, 7,  1, 76, 1040, 4};
    tbl[5] = '{100,  99, 1, 99, 1248, 5};

    // Reset state
    repeat (3) @(negedge clock);
    checkAll("reset", 0, 0, 0, 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset speed_valid", 32'(speed_valid), 0);
    reset = 1'b1;
    @(negedge clock);

    // Table-driven periods, circ = 208
    svBase = svCount;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].period == 0) applyStimulus(8, -1);
      else revPeriod(tbl[i].period);
      checkAll($sformatf("vec%0d", i), tbl[i].expSpeed, tbl[i].expMoving, tbl[i].expMax, tbl[i].expDist);
      checkOutput($sformatf("vec%0d valid count", i), 32'(svCount - svBase), tbl[i].expSv);
    end

    // Timeout: threshold per 5112 for circ 208, drop exactly 5120 clocks after the raw rise
    idle(5119 - 40);
    checkOutput("pre-timeout moving", 32'(moving), 1);
    checkOutput("pre-timeout speed", 32'(speed), 99);
    idle(1);
    checkAll("timeout", 0, 0, 99, 1248);
    checkOutput("timeout valid count", 32'(svCount - svBase), 5);

    // Bounce of 3 clocks is rejected
    idle(100);
    applyStimulus(3, -1);
    checkAll("bounce", 0, 0, 99, 1248);

    // Exactly DEBOUNCE clocks is accepted; restart from IDLE gives no division
    applyStimulus(4, -1);
    checkAll("restart", 0, 1, 99, 1456);
    checkOutput("restart valid count", 32'(svCount - svBase), 5);

    // Next revolution divides; check busy/strobe timing against the raw rise
    revPeriod(2048);
    checkAll("after restart", 7, 1, 99, 1664);
    checkOutput("after restart valid count", 32'(svCount - svBase), 6);
    checkOutput("busy before start", 32'(busyLog[6]), 0);
    checkOutput("busy at start", 32'(busyLog[7]), 1);
    checkOutput("busy last iter", 32'(busyLog[31]), 1);
    checkOutput("busy after done", 32'(busyLog[32]), 0);
    checkOutput("valid early", 32'(svLog[32]), 0);
    checkOutput("valid strobe", 32'(svLog[33]), 1);
    checkOutput("valid one cycle", 32'(svLog[34]), 0);

    // Clear then ten revolutions
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    checkAll("clear", 0, 0, 0, 0);
    applyStimulus(8, -1);
    for (int i = 0; i < 9; i++) revPeriod(300);
    checkAll("ten revs", 51, 1, 51, 2080);

    // Clear coinciding with a revolution wins
    svBase = svCount;
    idle(300 - 40);
    applyStimulus(8, 6);
    checkAll("clear with rev", 0, 0, 0, 0);
    idle(40);
    checkOutput("clear with rev valid", 32'(svCount - svBase), 0);

    // Async reset in the middle of a division
    applyStimulus(8, -1);
    revPeriod(500);
    checkAll("pre-reset", 30, 1, 30, 416);
    idle(500 - 40);
    for (int k = 0; k < 15; k++) begin
      reed = (k < 8);
      @(negedge clock);
    end
    checkOutput("mid-division busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    checkAll("async reset", 0, 0, 0, 0);
    checkOutput("async reset busy", 32'(busy), 0);
    checkOutput("async reset valid", 32'(speed_valid), 0);
    reed = 1'b0;
    repeat (3) @(negedge clock);
    reset  = 1'b1;
    svBase = svCount;
    idle(60);
    checkOutput("post-reset valid", 32'(svCount - svBase), 0);
    checkOutput("post-reset speed", 32'(speed), 0);

    // Randomized periods and circumferences against the model
    mMoving = 0; mSpeed = 0; mMax = 0; mValid = 0; mDist = 0;
    svBase = svCount;
    c = $urandom_range(100, 255);
    circ = 8'(c);
    applyStimulus(8, -1);
    modelRev(0, c);
    for (int i = 0; i < 14; i++) begin
      p = $urandom_range(45, 3500);
      c = $urandom_range(100, 255);
      circ = 8'(c);
      revPeriod(p);
      modelRev(p, c);
      checkAll($sformatf("rand%0d p=%0d c=%0d", i, p, c), mSpeed, mMoving, mMax, int'(mDist));
      checkOutput($sformatf("rand%0d valid count", i), 32'(svCount - svBase), mValid);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
